// File: rtl/alu_pkg.sv
// Shared encodings for the operand-entry front end and the ALU/display stage.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 3;

  // Entry FSM states; the encoding is also shown on the stage LEDs.
  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } entry_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/alu_operand_entry_if.sv
// Board-side bundle: raw switches/buttons in, latched operands/opcode/status out.
// Latency: n/a (wires only).
// Backpressure: none; outputs are level signals held until the next entry.
interface alu_operand_entry_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] sw;
  logic             btn_next;
  logic             btn_clr;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       op;
  logic             valid;
  logic [1:0]       stage;

  // master: the board / stimulus side
  modport master (
    output sw, btn_next, btn_clr,
    input  in1, in2, op, valid, stage
  );

  // slave: the entry logic
  modport slave (
    input  sw, btn_next, btn_clr,
    output in1, in2, op, valid, stage
  );

endinterface

// File: rtl/alu_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debouncer, 1-cycle press pulse.
// Latency: raw high first sampled at edge e0 -> stable rises at e0+D+1, pulse high the following cycle.
// Backpressure: none; releases produce no pulse, holding produces exactly one pulse.
// Ports: mclk, rst_n (sync, active-low), raw (async button), press_pulse (1-cycle on accepted press).
module alu_debounce #(
  parameter int DEBOUNCE_CYCLES = 16  // must be >= 2
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic raw,
  output logic press_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      if (sync2 != stable) begin
        // The edge that would bring the count to DEBOUNCE_CYCLES accepts the new level.
        if (cnt == CNT_LAST) begin
          stable <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        // Any sample agreeing with the stable level restarts the count.
        cnt <= '0;
      end
    end
  end

  assign press_pulse = stable & ~stable_q;

endmodule

// File: rtl/alu_operand_entry.sv
// Operand-entry FSM: latches A, B and opcode from sw on successive debounced presses.
// Latency: field/state write at e0+DEBOUNCE_CYCLES+2 after a press is first sampled.
// Backpressure: none; fields are held until overwritten or cleared, clear beats next.
// Ports: mclk, rst_n (sync, active-low), bus (slave: sw/btn_next/btn_clr in; in1/in2/op/valid/stage out).
module alu_operand_entry
  import alu_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               mclk,
  input  logic               rst_n,
  alu_operand_entry_if.slave bus
);

  logic next_pulse;
  logic clr_pulse;

  alu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .raw         (bus.btn_next),
    .press_pulse (next_pulse)
  );

  alu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .raw         (bus.btn_clr),
    .press_pulse (clr_pulse)
  );

  entry_state_e     state_q, state_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [1:0]       op_q, op_d;

  // Zero-extended switches so the opcode slice is legal for any WIDTH, including 1.
  logic [WIDTH+1:0] sw_ext;
  assign sw_ext = {2'b00, bus.sw};

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    if (clr_pulse) begin
      // Clear takes priority; a coincident next pulse is dropped.
      state_d = LOAD_A;
      in1_d   = '0;
      in2_d   = '0;
      op_d    = OP_ADD;
    end else if (next_pulse) begin
      case (state_q)
        LOAD_A: begin
          in1_d   = bus.sw;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          in2_d   = bus.sw;
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          op_d    = sw_ext[1:0];
          state_d = READY;
        end
        // Leaving READY keeps the old fields; they are overwritten one at a time.
        READY:   state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  assign bus.in1   = in1_q;
  assign bus.in2   = in2_q;
  assign bus.op    = op_q;
  assign bus.valid = (state_q == READY);
  assign bus.stage = state_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
module tb_alu_operand_entry;

  localparam int W = 3;
  localparam int D = 4;

  logic mclk;
  logic rst_n;

  alu_operand_entry_if #(.WIDTH(W)) bus ();

  alu_operand_entry #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;

  // Reference model: the entered fields and the entry position 0..3.
  int m_in1, m_in2, m_op, m_stage;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_in1"},   int'(bus.in1),   m_in1);
    chk({tag, "_in2"},   int'(bus.in2),   m_in2);
    chk({tag, "_op"},    int'(bus.op),    m_op);
    chk({tag, "_stage"}, int'(bus.stage), m_stage);
    chk({tag, "_valid"}, int'(bus.valid), (m_stage == 3) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_in1 = 0; m_in2 = 0; m_op = 0; m_stage = 0;
  endtask

  task automatic model_apply(input bit nx, input bit cl, input int swv);
    if (cl) begin
      model_reset();
    end else if (nx) begin
      case (m_stage)
        0: m_in1 = swv % 8;
        1: m_in2 = swv % 8;
        2: m_op  = swv % 4;
        default: ;
      endcase
      m_stage = (m_stage + 1) % 4;
    end
  endtask

  // Press with buttons held clean; checks the write lands exactly D+2 edges after the first sample.
  task automatic do_press(input string tag, input bit nx, input bit cl, input int swv);
    @(negedge mclk);
    bus.sw       = 3'(swv);
    bus.btn_next = nx;
    bus.btn_clr  = cl;
    repeat (D + 2) @(posedge mclk);
    #1;
    chk({tag, "_early_stage"}, int'(bus.stage), m_stage);
    @(posedge mclk);
    #1;
    model_apply(nx, cl, swv);
    check_all({tag, "_post"});
    @(negedge mclk);
    bus.btn_next = 1'b0;
    bus.btn_clr  = 1'b0;
    bus.sw       = 3'($urandom);
    repeat (D + 4) @(posedge mclk);
    #1;
    check_all({tag, "_hold"});
  endtask

  task automatic bounce_press(input int swv);
    @(negedge mclk);
    bus.sw = 3'(swv);
    for (int i = 0; i < 10; i++) begin
      bus.btn_next = (i % 2 == 0);
      repeat (2) @(negedge mclk);
    end
    chk("bounce_mid_stage", int'(bus.stage), m_stage);
    bus.btn_next = 1'b1;
    repeat (D + 8) @(negedge mclk);
    model_apply(1'b1, 1'b0, swv);
    check_all("bounce_held");
    bus.btn_next = 1'b0;
    repeat (D + 4) @(negedge mclk);
    check_all("bounce_rel");
  endtask

  task automatic glitch(input int len);
    @(negedge mclk);
    bus.sw       = 3'($urandom);
    bus.btn_next = 1'b1;
    repeat (len) @(negedge mclk);
    bus.btn_next = 1'b0;
    repeat (D + 4) @(negedge mclk);
    check_all("glitch");
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.sw       = 3'($urandom);
    bus.btn_next = 1'b0;
    bus.btn_clr  = 1'b0;
    model_reset();
    repeat (3) @(posedge mclk);
    #1;
    check_all("reset");
    @(negedge mclk);
    rst_n = 1'b1;

    // Full entry 011 / 001 / 000
    do_press("e1a", 1'b1, 1'b0, 3);
    do_press("e1b", 1'b1, 1'b0, 1);
    do_press("e1c", 1'b1, 1'b0, 0);
    chk("e1_in1",   int'(bus.in1),   3);
    chk("e1_in2",   int'(bus.in2),   1);
    chk("e1_op",    int'(bus.op),    0);
    chk("e1_valid", int'(bus.valid), 1);
    chk("e1_stage", int'(bus.stage), 3);
    do_press("e1d", 1'b1, 1'b0, 6);

    // Entry 101 / 010 / 01, then a fourth press
    do_press("e2a", 1'b1, 1'b0, 5);
    do_press("e2b", 1'b1, 1'b0, 2);
    do_press("e2c", 1'b1, 1'b0, 1);
    chk("e2_valid", int'(bus.valid), 1);
    chk("e2_op",    int'(bus.op),    1);
    do_press("e2d", 1'b1, 1'b0, 7);
    chk("e2_after_valid", int'(bus.valid), 0);
    chk("e2_after_stage", int'(bus.stage), 0);
    chk("e2_after_in1",   int'(bus.in1),   5);
    chk("e2_after_in2",   int'(bus.in2),   2);

    // LOAD_B with in1=4, then clear and next in the same cycle
    do_press("c_a", 1'b1, 1'b0, 4);
    chk("c_pre_in1", int'(bus.in1), 4);
    do_press("c_both", 1'b1, 1'b1, 6);
    chk("c_in1",   int'(bus.in1),   0);
    chk("c_stage", int'(bus.stage), 0);

    // Reach LOAD_OP, then reset in the middle of a debounce count
    do_press("r_a", 1'b1, 1'b0, 7);
    do_press("r_b", 1'b1, 1'b0, 6);
    chk("r_pre_stage", int'(bus.stage), 2);
    @(negedge mclk);
    bus.btn_next = 1'b1;
    repeat (4) @(negedge mclk);
    rst_n = 1'b0;
    @(negedge mclk);
    rst_n        = 1'b1;
    bus.btn_next = 1'b0;
    model_reset();
    check_all("r_now");
    repeat (D + 8) @(negedge mclk);
    check_all("r_later");

    // Division-by-zero setup is passed through unchanged
    do_press("dz_a", 1'b1, 1'b0, 4);
    do_press("dz_b", 1'b1, 1'b0, 0);
    do_press("dz_c", 1'b1, 1'b0, 3);
    chk("dz_in1",   int'(bus.in1),   4);
    chk("dz_in2",   int'(bus.in2),   0);
    chk("dz_op",    int'(bus.op),    3);
    chk("dz_valid", int'(bus.valid), 1);

    // Bouncy press: one advance only
    bounce_press(5);

    // Randomized mix against the model
    for (int k = 0; k < 30; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      do_press("rnd_next", 1'b1, 1'b0, $urandom_range(0, 7));
      else if (r == 6) do_press("rnd_clr", 1'b0, 1'b1, $urandom_range(0, 7));
      else if (r == 7) do_press("rnd_both", 1'b1, 1'b1, $urandom_range(0, 7));
      else if (r == 8) glitch($urandom_range(1, D - 1));
      else             bounce_press($urandom_range(0, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_entry.md
# alu_operand_entry

Operand-entry front end for the ALU display stage. It takes raw board switches and two push-buttons, debounces and synchronises the buttons, and runs a sequential entry FSM. The FSM latches operand A, operand B and the opcode one press at a time, then presents them as stable `in1`, `in2` and `op` with a `valid` flag. Its outputs drive the ALU/7-segment stage directly.

## Interface
Parameters
- `WIDTH`, 3: operand width; must match the downstream ALU.
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples required to accept a button level change. Use 16 for simulation and about 500000 on the board. Must be ≥ 2.

Ports
- `mclk` input 1: system clock. Single clock domain.
- `rst_n` input 1: reset, synchronous, active-low.
- `sw` input WIDTH: raw data switches, treated as quasi-static. Not synchronised for data; sampled only on write edges.
- `btn_next` input 1: raw, asynchronous, bouncy "enter/advance" button, active-high.
- `btn_clr` input 1: raw, asynchronous, bouncy "clear" button, active-high.
- `in1` output WIDTH: latched operand A.
- `in2` output WIDTH: latched operand B.
- `op` output 2: latched opcode. 00 add, 01 sub, 10 mul, 11 div.
- `valid` output 1: high while all three fields are entered (state READY).
- `stage` output 2: current FSM state encoding, for LED indication.

## Operation
- Each button goes through its own debouncer:
  - 2-flop synchroniser, then counter.
  - The counter increments on every edge where the synchronised level ≠ the stable level.
  - The counter clears on any edge where they are equal.
  - On the edge where the counter would reach `DEBOUNCE_CYCLES`, the stable level toggles and the counter clears.
- Press pulse = stable & ~stable_q. It is a 1-cycle pulse on the 0→1 transition only; releases generate nothing.
- FSM states (stage encoding): LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3.
  - LOAD_A + next press: `in1`←`sw`, go to LOAD_B.
  - LOAD_B + next press: `in2`←`sw`, go to LOAD_OP.
  - LOAD_OP + next press: `op`←`sw[1:0]`, go to READY. If WIDTH < 2, zero-extend.
  - READY + next press: hold `in1`/`in2`/`op`, go to LOAD_A. `valid` drops. New entries overwrite fields one at a time.
- Clear press, in any state: `in1`, `in2`, `op` ← 0 and state ← LOAD_A.
- Clear and next pulses in the same cycle: clear wins and the next pulse is discarded.
- Holding a button produces exactly one pulse; a second pulse requires a debounced release.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles produce no pulse.
- Reset (`rst_n`=0 at an edge), including mid-debounce or mid-entry:
  - state LOAD_A; `in1`=`in2`=0, `op`=00, `valid`=0, `stage`=00.
  - Synchronisers, counters and stable levels all 0.
  - No pulse is emitted after reset release unless the button is still held long enough to be re-accepted.

## Timing
- All outputs are registered. `valid` and `stage` decode from the state register with no combinational path from `sw` or the buttons.
- Latency: let edge e0 be the first edge sampling a button high, with the input held high.
  - Stable level rises at edge e0+D+1, where D=`DEBOUNCE_CYCLES`.
  - Pulse is high for the cycle following e0+D+1.
  - Registers and state update at edge e0+D+2.
- `sw` is sampled only at the write edge (e0+D+2). Changes to `sw` at other times have no effect.
- `valid` rises on the same edge that writes `op`, and falls on the edge that leaves READY.

## Structure
- Shared package `alu_pkg`: state encodings (LOAD_A..READY), opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV), default `WIDTH`. The same constants are used by the ALU/display stage.
- One sub-module, `alu_debounce` (parameter `DEBOUNCE_CYCLES`; ports `mclk`, `rst_n`, raw, press_pulse), instantiated twice.
- Top module contains the FSM and the operand registers only.

## Test plan
- Reset, then full entry with D=4:
  - Stimulus: `sw`=011 plus next press, `sw`=001 plus press, `sw`=000 plus press.
  - Required: `in1`=3, `in2`=1, `op`=00, `valid`=1, `stage`=3. Each write lands exactly 6 edges after its press starts.
- Bounce rejection: `btn_next` toggling every 2 cycles for 20 cycles, then held high → exactly one pulse, and state advances by exactly 1.
- Entry 101/010/01 followed by a fourth press: `valid`=1 with `op`=01, then `valid`=0 and `stage`=0, with `in1`=5 and `in2`=2 retained until overwritten.
- Clear and next pulses forced into the same cycle while in LOAD_B with `in1`=4 → all fields 0, `stage`=0, no advance.
- `rst_n` low for 1 edge at the midpoint of a debounce count in state LOAD_OP → all outputs 0, `stage`=0, and no pulse emitted from the aborted count.
- Division-by-zero setup `in1`=100, `in2`=000, `op`=11 → `valid`=1 and fields passed unchanged; error handling is downstream.
